haraka_sponge_ctrl: RTL and testbench

//  Parametrised byte-stream sponge controller for Haraka-S: absorbs a message with valid/ready handshake,

---
 rtl/haraka_sponge_ctrl_if.sv | 37 +++
 rtl/haraka_sponge_ctrl.sv | 166 ++++++++++++++++
 tb/tb_haraka_sponge_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/haraka_sponge_ctrl_if.sv
`default_nettype none
// =============================================================================
// haraka_sponge_ctrl_if : config, message/digest streams and permutation-core bundle
// Revision 1.0
// =============================================================================
interface haraka_sponge_ctrl_if #(
   parameter int STATE_BITS = 512,
   parameter int LEN_W      = 16
);
   logic                  start;
   logic [LEN_W-1:0]      cfg_len;
   logic                  cfg_empty;
   logic [7:0]            in_data;
   logic                  in_valid;
   logic                  in_last;
   logic                  in_ready;
   logic [7:0]            out_data;
   logic                  out_valid;
   logic                  out_last;
   logic                  out_ready;
   logic                  perm_start;
   logic [STATE_BITS-1:0] perm_in;
   logic [STATE_BITS-1:0] perm_out;
   logic                  perm_done;
   logic                  busy;

   // slave is the sponge controller, master is its environment
   modport slave (
      input  start, cfg_len, cfg_empty, in_data, in_valid, in_last, out_ready, perm_out, perm_done,
      output in_ready, out_data, out_valid, out_last, perm_start, perm_in, busy
   );
   modport master (
      output start, cfg_len, cfg_empty, in_data, in_valid, in_last, out_ready, perm_out, perm_done,
      input  in_ready, out_data, out_valid, out_last, perm_start, perm_in, busy
   );
endinterface
`default_nettype wire

// File: rtl/haraka_sponge_ctrl.sv
`default_nettype none
// =============================================================================
// haraka_sponge_ctrl : byte-stream Haraka-S sponge (absorb, pad, squeeze) driving an external permutation
// Revision 1.0
// =============================================================================
module haraka_sponge_ctrl #(
   parameter int         STATE_BITS = 512,
   parameter int         RATE_BITS  = 256,
   parameter int         LEN_W      = 16,
   parameter logic [7:0] PAD_FIRST  = 8'h1F,
   parameter logic [7:0] PAD_LAST   = 8'h80
) (
   input wire                   clk_i,
   input wire                   reset_i,
   haraka_sponge_ctrl_if.slave  bus
);
   localparam int c_RB    = RATE_BITS / 8;
   localparam int c_IDX_W = $clog2(c_RB);
   localparam int c_CAP   = STATE_BITS - RATE_BITS;
   localparam logic [c_IDX_W-1:0]    c_IDX_MAX  = c_IDX_W'(c_RB - 1);
   localparam logic [STATE_BITS-1:0] c_LAST_VEC = {{(RATE_BITS-8){1'b0}}, PAD_LAST, {c_CAP{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ABSORB  = 3'd1,
      S_PERM_A  = 3'd2,
      S_PAD     = 3'd3,
      S_PERM_F  = 3'd4,
      S_SQUEEZE = 3'd5,
      S_PERM_S  = 3'd6
   } state_e;

   state_e                state_q, state_d;
   logic [STATE_BITS-1:0] st_q, st_d;
   logic [c_IDX_W-1:0]    idx_q, idx_d;
   logic [LEN_W-1:0]      rem_q, rem_d;
   logic                  first_q, first_d;
   logic                  lastp_q, lastp_d;

   logic                  w_idx_wrap;
   logic [c_IDX_W-1:0]    w_idx_inc;
   logic [c_IDX_W+2:0]    w_shamt;
   logic [STATE_BITS-1:0] w_in_vec;
   logic [STATE_BITS-1:0] w_pad_vec;
   logic [7:0]            w_out_byte;
   logic                  w_done;

   assign w_idx_wrap = (idx_q == c_IDX_MAX);
   assign w_idx_inc  = w_idx_wrap ? '0 : idx_q + c_IDX_W'(1);
   assign w_shamt    = {idx_q, 3'b000};
   assign w_in_vec   = {bus.in_data, {(STATE_BITS-8){1'b0}}} >> w_shamt;
   assign w_pad_vec  = ({PAD_FIRST, {(STATE_BITS-8){1'b0}}} >> w_shamt) ^ c_LAST_VEC;
   // a done coinciding with our own start pulse is stale and must not complete the permutation
   assign w_done     = bus.perm_done & ~first_q;

   always_comb begin
      w_out_byte = '0;
      for (int k = 0; k < c_RB; k++) begin
         if (idx_q == c_IDX_W'(k)) begin
            w_out_byte = st_q[STATE_BITS-1-8*k -: 8];
         end
      end
   end

   assign bus.out_data = w_out_byte;
   assign bus.perm_in  = st_q;
   assign bus.busy     = (state_q != S_IDLE);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         st_q    <= '0;
         idx_q   <= '0;
         rem_q   <= '0;
         first_q <= 1'b0;
         lastp_q <= 1'b0;
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         idx_q   <= idx_d;
         rem_q   <= rem_d;
         first_q <= first_d;
         lastp_q <= lastp_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      st_d           = st_q;
      idx_d          = idx_q;
      rem_d          = rem_q;
      first_d        = 1'b0;
      lastp_d        = lastp_q;
      bus.in_ready   = 1'b0;
      bus.out_valid  = 1'b0;
      bus.out_last   = 1'b0;
      bus.perm_start = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               st_d    = '0;
               idx_d   = '0;
               rem_d   = bus.cfg_len;
               lastp_d = 1'b0;
               state_d = bus.cfg_empty ? S_PAD : S_ABSORB;
            end
         end
         S_ABSORB: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               st_d  = st_q ^ w_in_vec;
               idx_d = w_idx_inc;
               // a message ending on a block boundary is permuted first, then padded in a fresh block
               if (w_idx_wrap) begin
                  lastp_d = bus.in_last;
                  first_d = 1'b1;
                  state_d = S_PERM_A;
               end else if (bus.in_last) begin
                  state_d = S_PAD;
               end
            end
         end
         S_PAD: begin
            st_d    = st_q ^ w_pad_vec;
            first_d = 1'b1;
            state_d = S_PERM_F;
         end
         S_PERM_A, S_PERM_F, S_PERM_S: begin
            bus.perm_start = first_q;
            if (w_done) begin
               st_d = bus.perm_out;
               if (state_q == S_PERM_A) begin
                  lastp_d = 1'b0;
                  state_d = lastp_q ? S_PAD : S_ABSORB;
               end else if (state_q == S_PERM_F) begin
                  idx_d   = '0;
                  state_d = (rem_q == '0) ? S_IDLE : S_SQUEEZE;
               end else begin
                  state_d = S_SQUEEZE;
               end
            end
         end
         S_SQUEEZE: begin
            bus.out_valid = 1'b1;
            bus.out_last  = (rem_q == LEN_W'(1));
            if (bus.out_ready) begin
               if (rem_q != '0) begin
                  rem_d = rem_q - LEN_W'(1);
               end
               idx_d = w_idx_inc;
               if (rem_q <= LEN_W'(1)) begin
                  state_d = S_IDLE;
               end else if (w_idx_wrap) begin
                  first_d = 1'b1;
                  state_d = S_PERM_S;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end
endmodule
`default_nettype wire

// File: tb/tb_haraka_sponge_ctrl.sv
`default_nettype none
// =============================================================================
// tb_haraka_sponge_ctrl : directed scoreboard bench with a behavioural permutation core
// Revision 1.0
// =============================================================================
module tb_haraka_sponge_ctrl;
   localparam int SB = 512;
   localparam int RB = 32;
   localparam int LW = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   haraka_sponge_ctrl_if #(.STATE_BITS(SB), .LEN_W(LW)) bus ();

   haraka_sponge_ctrl #(
      .STATE_BITS(SB), .RATE_BITS(256), .LEN_W(LW), .PAD_FIRST(8'h1F), .PAD_LAST(8'h80)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   int            n_chk = 0;
   int            n_bad = 0;
   int            n_perm = 0;
   int            core_lat = 1;
   int            ready_mode = 0;
   bit            spur_req = 1'b0;
   logic [SB-1:0] exp_perm_q[$];
   logic [8:0]    exp_out_q[$];
   logic [SB-1:0] perm_log[$];
   logic          prev_stall = 1'b0;
   logic [8:0]    prev_out = '0;

   task automatic chk(input string name, input logic [SB-1:0] act, input logic [SB-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [SB-1:0] perm_f(input logic [SB-1:0] x);
      return {x[SB-9:0], x[SB-1:SB-8]} ^ {16{32'h9E3779B9}};
   endfunction

   // reference sponge: queues every expected perm_in and digest byte
   task automatic model(input logic [7:0] msg[$], input int len);
      logic [SB-1:0] s;
      int k;
      s = '0;
      foreach (msg[i]) begin
         k = i % RB;
         s[SB-1-8*k -: 8] ^= msg[i];
         if (k == RB-1) begin
            exp_perm_q.push_back(s);
            s = perm_f(s);
         end
      end
      k = msg.size() % RB;
      s[SB-1-8*k -: 8]      ^= 8'h1F;
      s[SB-1-8*(RB-1) -: 8] ^= 8'h80;
      exp_perm_q.push_back(s);
      s = perm_f(s);
      for (int j = 0; j < len; j++) begin
         k = j % RB;
         if (j > 0 && k == 0) begin
            exp_perm_q.push_back(s);
            s = perm_f(s);
         end
         exp_out_q.push_back({(j == len-1), s[SB-1-8*k -: 8]});
      end
   endtask

   // permutation core: latency core_lat cycles, aborts on reset
   initial begin
      bus.perm_done = 1'b0;
      bus.perm_out  = '0;
      forever begin
         @(posedge clk); #1;
         bus.perm_done = 1'b0;
         if (!reset && spur_req) begin
            bus.perm_out  = {16{32'hDEADBEEF}};
            bus.perm_done = 1'b1;
            spur_req      = 1'b0;
         end else if (!reset && bus.perm_start) begin : job
            logic [SB-1:0] cap;
            bit ab;
            cap = bus.perm_in;
            ab  = 1'b0;
            repeat (core_lat) begin
               @(posedge clk); #1;
               if (reset) ab = 1'b1;
            end
            if (!ab) begin
               bus.perm_out  = perm_f(cap);
               bus.perm_done = 1'b1;
            end
         end
      end
   end

   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         bus.out_ready = (ready_mode == 0) ? 1'b1 : ~bus.out_ready;
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (bus.perm_start) begin
            n_perm++;
            perm_log.push_back(bus.perm_in);
            if (exp_perm_q.size() == 0) begin
               n_chk++; n_bad++;
               $display("FAIL perm_in: unexpected perm_start, got %0h", bus.perm_in);
            end else begin
               chk("perm_in", bus.perm_in, exp_perm_q.pop_front());
            end
         end
         if (prev_stall) begin
            chk("stall_hold", SB'({bus.out_valid, bus.out_last, bus.out_data}), SB'({1'b1, prev_out}));
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_out_q.size() == 0) begin
               n_chk++; n_bad++;
               $display("FAIL out_byte: unexpected byte %0h last %0b", bus.out_data, bus.out_last);
            end else begin
               chk("out_byte", SB'({bus.out_last, bus.out_data}), SB'(exp_out_q.pop_front()));
            end
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_out   = {bus.out_last, bus.out_data};
      end
   end

   task automatic start_hash(input int len, input bit empty);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.cfg_len   = LW'(len);
      bus.cfg_empty = empty;
      @(negedge clk);
      bus.start     = 1'b0;
      bus.cfg_empty = 1'b0;
   endtask

   task automatic send_bytes(input logic [7:0] msg[$], input int gap, input bit mark_last);
      int t;
      foreach (msg[i]) begin
         bus.in_valid = 1'b1;
         bus.in_data  = msg[i];
         bus.in_last  = mark_last && (i == msg.size()-1);
         t = 0;
         while (!bus.in_ready && t < 300) begin
            @(negedge clk);
            t++;
         end
         if (t >= 300) chk("in_ready_timeout", SB'(t), SB'(0));
         @(negedge clk);
         if (gap > 0) begin
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b1;
            repeat (gap) @(negedge clk);
         end
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (bus.busy && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) chk("idle_timeout", SB'(t), SB'(0));
   endtask

   task automatic run(input string name, input logic [7:0] msg[$], input int len, input int gap,
                      input int exp_perms);
      model(msg, len);
      perm_log.delete();
      n_perm = 0;
      start_hash(len, msg.size() == 0);
      send_bytes(msg, gap, 1'b1);
      wait_idle();
      repeat (2) @(negedge clk);
      chk({name, "_perms"}, SB'(n_perm), SB'(exp_perms));
      chk({name, "_left"}, SB'(exp_perm_q.size() + exp_out_q.size()), SB'(0));
   endtask

   initial begin : main
      logic [7:0]    m[$];
      logic [SB-1:0] hv;
      int            t;
      bus.start = 1'b0; bus.cfg_len = '0; bus.cfg_empty = 1'b0;
      bus.in_data = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy",       SB'(bus.busy),       SB'(0));
      chk("rst_in_ready",   SB'(bus.in_ready),   SB'(0));
      chk("rst_out_valid",  SB'(bus.out_valid),  SB'(0));
      chk("rst_out_last",   SB'(bus.out_last),   SB'(0));
      chk("rst_perm_start", SB'(bus.perm_start), SB'(0));
      reset = 1'b0;

      // empty message, 32-byte digest
      m = {};
      run("empty", m, 32, 0, 1);
      hv = '0; hv[511:504] = 8'h1F; hv[263:256] = 8'h80;
      chk("empty_perm_in", perm_log[0], hv);

      // 31 bytes: both pad bytes collide in slot 31
      core_lat = 2;
      m = {};
      for (int i = 0; i < 31; i++) m.push_back(8'(i));
      run("m31", m, 32, 0, 1);
      hv = '0;
      for (int k = 0; k < 31; k++) hv[SB-1-8*k -: 8] = 8'(k);
      hv[263:256] = 8'h9F;
      chk("m31_perm_in", perm_log[0], hv);

      // exactly one full block: padding goes into a second block
      core_lat = 1;
      m = {};
      for (int i = 0; i < 32; i++) m.push_back(8'(3*i + 1));
      run("m32", m, 32, 0, 2);

      // 80-byte digest under 50% back-pressure
      core_lat = 3; ready_mode = 1;
      m = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
      run("sq80", m, 80, 0, 3);

      // zero-length digest
      core_lat = 1; ready_mode = 0;
      m = {8'h11, 8'h22, 8'h33};
      run("len0", m, 0, 0, 1);

      // multi-block message with input gaps and stray in_last
      core_lat = 3;
      m = {};
      for (int i = 0; i < 70; i++) m.push_back(8'(255 - 2*i));
      run("m70", m, 33, 1, 4);

      // reset while PERM_A is outstanding with in_valid held high
      core_lat = 4;
      m = {};
      for (int i = 0; i < 32; i++) m.push_back(8'(i));
      hv = '0;
      for (int k = 0; k < 32; k++) hv[SB-1-8*k -: 8] = 8'(k);
      exp_perm_q.push_back(hv);
      start_hash(40, 1'b0);
      send_bytes(m, 0, 1'b0);
      bus.in_valid = 1'b1; bus.in_data = 8'hAA;
      chk("pa_in_ready", SB'(bus.in_ready), SB'(0));
      chk("pa_busy",     SB'(bus.busy),     SB'(1));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("ra_busy",       SB'(bus.busy),       SB'(0));
      chk("ra_in_ready",   SB'(bus.in_ready),   SB'(0));
      chk("ra_perm_start", SB'(bus.perm_start), SB'(0));
      chk("ra_out_valid",  SB'(bus.out_valid),  SB'(0));
      chk("ra_perm_left",  SB'(exp_perm_q.size()), SB'(0));
      reset = 1'b0; bus.in_valid = 1'b0;
      exp_out_q.delete();
      repeat (8) @(negedge clk);
      chk("ra_idle", SB'({bus.busy, bus.in_ready}), SB'(0));
      for (int i = 32; i < 40; i++) m.push_back(8'(i));
      run("post_rst", m, 40, 0, 3);

      // spurious done in IDLE, then a start issued mid-squeeze
      core_lat = 1; ready_mode = 1;
      spur_req = 1'b1;
      repeat (3) @(negedge clk);
      chk("spur_busy", SB'(bus.busy), SB'(0));
      m = {};
      for (int i = 0; i < 10; i++) m.push_back(8'(8'h40 + i));
      fork
         run("inj", m, 40, 0, 2);
         begin
            t = 0;
            while (!bus.out_valid && t < 500) begin
               @(negedge clk);
               t++;
            end
            if (t >= 500) chk("inj_timeout", SB'(t), SB'(0));
            @(negedge clk);
            bus.start = 1'b1; bus.cfg_len = LW'(5); bus.cfg_empty = 1'b1;
            @(negedge clk);
            bus.start = 1'b0; bus.cfg_empty = 1'b0;
         end
      join

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", n_bad);
      $fatal(1);
   end
endmodule
`default_nettype wire
